// File: rtl/axi_lite_reg_master.sv
// axi_lite_reg_master: single-beat AXI4-Lite initiator for the DDR test
// register bus; one transaction in flight, per-phase timeout, orphan drain.
module axi_lite_reg_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  // command stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  // response stream
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // write address
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  // write data
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  output logic                    axi_wlast,
  input  logic                    axi_wready,
  // write response
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  // read address
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  // read data
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_AW,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_e;

  localparam int TW_NEED = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW      = (TW_NEED > 16) ? TW_NEED : 16;
  localparam bit TMO_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e                  state_q;
  logic [TW-1:0]           tmr_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    arvalid_q;
  logic                    bready_q;
  logic                    rready_q;
  logic                    rsp_valid_q;
  logic                    rsp_write_q;
  logic                    rsp_timeout_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;

  logic aw_hold;
  logic w_hold;
  logic wr_addr_done;
  logic tmo_hit;
  logic unused_rlast;

  // AW and W are tracked independently; the write address phase ends
  // once neither channel still has an unaccepted beat.
  assign aw_hold      = awvalid_q && !axi_awready;
  assign w_hold       = wvalid_q && !axi_wready;
  assign wr_addr_done = !aw_hold && !w_hold;
  assign tmo_hit      = TMO_EN && (tmr_q == TMO_LAST);
  assign unused_rlast = axi_rlast;

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = '1;
  assign axi_wvalid  = wvalid_q;
  assign axi_wlast   = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

  // Transaction sequencer with registered AXI and response outputs.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      write_q       <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bready_q <= 1'b1;
          rready_q <= 1'b1;
          if (cmd_valid) begin
            write_q  <= cmd_write;
            tmr_q    <= '0;
            bready_q <= 1'b0;
            rready_q <= 1'b0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR_AW: begin
          if (awvalid_q && axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && axi_wready) wvalid_q <= 1'b0;
          if (wr_addr_done) begin
            tmr_q    <= '0;
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end else if (tmo_hit) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b1;
            rready_q      <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= write_q;
            rsp_timeout_q <= 1'b1;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_rdata_q   <= '0;
            state_q       <= RSP;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        WR_B: begin
          if (axi_bvalid) begin
            rready_q      <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= write_q;
            rsp_timeout_q <= 1'b0;
            rsp_resp_q    <= axi_bresp;
            rsp_rdata_q   <= '0;
            state_q       <= RSP;
          end else if (tmo_hit) begin
            rready_q      <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= write_q;
            rsp_timeout_q <= 1'b1;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_rdata_q   <= '0;
            state_q       <= RSP;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        RD_AR: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            tmr_q     <= '0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end else if (tmo_hit) begin
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b1;
            rready_q      <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= write_q;
            rsp_timeout_q <= 1'b1;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_rdata_q   <= '0;
            state_q       <= RSP;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        RD_R: begin
          if (axi_rvalid) begin
            bready_q      <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= write_q;
            rsp_timeout_q <= 1'b0;
            rsp_resp_q    <= axi_rresp;
            rsp_rdata_q   <= axi_rdata;
            state_q       <= RSP;
          end else if (tmo_hit) begin
            bready_q      <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= write_q;
            rsp_timeout_q <= 1'b1;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_rdata_q   <= '0;
            state_q       <= RSP;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// tb_axi_lite_reg_master: randomized AXI-Lite slave with per-channel
// delays, checked against a transaction-level reference model.
module tb_axi_lite_reg_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr;
  logic        axi_awvalid, axi_wvalid, axi_wlast, axi_arvalid;
  logic [3:0]  axi_wstrb;
  logic        axi_bready, axi_rready;
  logic        axi_awready = 1'b0;
  logic        axi_wready = 1'b0;
  logic        axi_arready = 1'b0;
  logic        axi_bvalid = 1'b0;
  logic        axi_rvalid = 1'b0;
  logic        axi_rlast = 1'b0;
  logic [1:0]  axi_bresp = 2'b00;
  logic [1:0]  axi_rresp = 2'b00;
  logic [31:0] axi_rdata = 32'h0;

  always #5 clk = ~clk;

  axi_lite_reg_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast),
    .axi_rready(axi_rready)
  );

  int n_vec = 0;
  int n_err = 0;
  bit abort_run = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave configuration for the current transaction
  int          cfg_awd = 0, cfg_wd = 0, cfg_bd = 0;
  int          cfg_ard = 0, cfg_rd = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cur_addr = 32'h0, cur_data = 32'h0;

  // slave bookkeeping
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit aw_done = 0, w_done = 0, b_armed = 0;
  bit b_pend = 0, b_fire = 0, r_pend = 0, r_fire = 0;
  int aw_beats = 0, w_beats = 0, ar_beats = 0, bad = 0;
  logic [31:0] cap_addr = 32'h0, cap_data = 32'h0, r_addr = 32'h0;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Slave: decides ready/valid on each falling edge; a valid&&ready
  // pair seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      axi_awready = 0; axi_wready = 0; axi_arready = 0;
      axi_bvalid = 0; axi_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_done = 0; w_done = 0; b_armed = 0;
      b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
    end else begin
      if (b_fire) begin axi_bvalid = 0; b_fire = 0; end
      if (b_pend) begin
        if (b_cnt >= cfg_bd) begin
          axi_bvalid = 1; axi_bresp = cfg_bresp; b_pend = 0;
        end else b_cnt++;
      end
      if (axi_bvalid && axi_bready) b_fire = 1;

      if (r_fire) begin axi_rvalid = 0; r_fire = 0; end
      if (r_pend) begin
        if (r_cnt >= cfg_rd) begin
          axi_rvalid = 1; axi_rresp = cfg_rresp;
          axi_rdata = slv_mem.exists(r_addr) ? slv_mem[r_addr] : 32'h0;
          r_pend = 0;
        end else r_cnt++;
      end
      if (axi_rvalid && axi_rready) r_fire = 1;

      if (axi_wlast !== axi_wvalid) bad++;
      if (axi_awvalid) begin
        if (axi_awaddr !== cur_addr) bad++;
        axi_awready = (aw_cnt >= cfg_awd);
        if (axi_awready) begin
          aw_beats++; aw_cnt = 0; aw_done = 1; cap_addr = axi_awaddr;
        end else aw_cnt++;
      end else begin
        axi_awready = 0; aw_cnt = 0;
      end
      if (axi_wvalid) begin
        if (axi_wdata !== cur_data || axi_wstrb !== 4'hF) bad++;
        axi_wready = (w_cnt >= cfg_wd);
        if (axi_wready) begin
          w_beats++; w_cnt = 0; w_done = 1; cap_data = axi_wdata;
        end else w_cnt++;
      end else begin
        axi_wready = 0; w_cnt = 0;
      end
      if (aw_done && w_done && !b_armed) begin
        b_armed = 1; b_pend = 1; b_cnt = 0;
        slv_mem[cap_addr] = cap_data;
      end
      if (axi_arvalid) begin
        if (axi_araddr !== cur_addr) bad++;
        axi_arready = (ar_cnt >= cfg_ard);
        if (axi_arready) begin
          ar_beats++; ar_cnt = 0; r_addr = axi_araddr;
          r_pend = 1; r_cnt = 0;
        end else ar_cnt++;
      end else begin
        axi_arready = 0; ar_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    int orphan = 0;
    while ((b_pend || axi_bvalid || r_pend || axi_rvalid || !cmd_ready)
           && n < 100) begin
      if (rsp_valid) orphan++;
      @(negedge clk); #1;
      n++;
    end
    chk("idle_reached", (n < 100), 1);
    chk("no_orphan_rsp", orphan, 0);
  endtask

  task automatic start_txn(input bit wr, input logic [31:0] addr,
                           input logic [31:0] data);
    aw_beats = 0; w_beats = 0; ar_beats = 0; bad = 0;
    aw_done = 0; w_done = 0; b_armed = 0;
    cur_addr = addr; cur_data = data;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    @(negedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr,
                        input logic [31:0] data,
                        input int awd, input int wd, input int bd,
                        input int ard, input int rd,
                        input logic [1:0] bresp, input logic [1:0] rresp,
                        input int hold);
    bit tmo;
    logic [31:0] rv;
    logic [35:0] exp_rsp;
    logic [35:0] got;
    int n;
    wait_idle();
    cfg_awd = awd; cfg_wd = wd; cfg_bd = bd;
    cfg_ard = ard; cfg_rd = rd;
    cfg_bresp = bresp; cfg_rresp = rresp;
    // reference: a phase times out when its slave wait reaches TMO
    if (wr) tmo = (awd >= TMO) || (wd >= TMO) || (bd >= TMO);
    else    tmo = (ard >= TMO) || (rd >= TMO);
    rv = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    exp_rsp = {wr, tmo, tmo ? 2'b10 : (wr ? bresp : rresp),
               (tmo || wr) ? 32'h0 : rv};
    if (wr && awd < TMO && wd < TMO) ref_mem[addr] = data;
    start_txn(wr, addr, data);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("rsp_wait", 0, 1);
      abort_run = 1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      got = {rsp_write, rsp_timeout, rsp_resp, rsp_rdata};
      chk("rsp_hold", got, exp_rsp);
      chk("cmd_ready_busy", cmd_ready, 0);
      @(negedge clk); #1;
    end
    rsp_ready = 1;
    got = {rsp_write, rsp_timeout, rsp_resp, rsp_rdata};
    chk("rsp", got, exp_rsp);
    chk("rsp_valid", rsp_valid, 1);
    @(negedge clk); #1;
    rsp_ready = 0;
    chk("rsp_released", {rsp_valid, cmd_ready}, 2'b01);
    chk("aw_beats", aw_beats, (wr && awd < TMO) ? 1 : 0);
    chk("w_beats", w_beats, (wr && wd < TMO) ? 1 : 0);
    chk("ar_beats", ar_beats, (!wr && ard < TMO) ? 1 : 0);
    chk("bus_stable", bad, 0);
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return $urandom_range(0, 3);
    if (r == 14) return 15;
    if (r == 15) return 16;
    if (r == 16) return 20;
    return $urandom_range(4, 8);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl", {cmd_ready, axi_awvalid, axi_wvalid, axi_arvalid,
                    axi_bready, axi_rready, rsp_valid, rsp_timeout},
        8'b1000_0000);
    chk("rst_rsp", {rsp_resp, rsp_rdata}, 0);
    chk("rst_addr", {axi_awaddr, axi_araddr}, 0);
    chk("rst_wdata", axi_wdata, 0);
    @(negedge clk); #1;
    rst_n = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_drain_ready", {axi_bready, axi_rready}, 2'b11);

    // directed cases
    do_txn(1, 32'h08, 32'h2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    do_txn(1, 32'h2C, 32'hDEADBEEF, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
    do_txn(0, 32'h2C, 32'h0, 0, 0, 0, 0, 3, 2'b00, 2'b00, 0);
    do_txn(1, 32'h10, 32'h11, 4, 0, 0, 0, 0, 2'b01, 2'b00, 1);
    do_txn(1, 32'h14, 32'h22, 0, 4, 2, 0, 0, 2'b00, 2'b00, 0);
    do_txn(1, 32'h18, 32'h33, 15, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    do_txn(1, 32'h1C, 32'h44, 16, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    do_txn(1, 32'h20, 32'h55, 0, 0, 15, 0, 0, 2'b11, 2'b00, 0);
    do_txn(1, 32'h24, 32'h66, 0, 0, 16, 0, 0, 2'b00, 2'b00, 0);
    do_txn(0, 32'h18, 32'h0, 0, 0, 0, 15, 0, 2'b00, 2'b01, 0);
    do_txn(0, 32'h1C, 32'h0, 0, 0, 0, 16, 0, 2'b00, 2'b00, 0);
    do_txn(0, 32'h20, 32'h0, 0, 0, 0, 0, 15, 2'b00, 2'b00, 0);
    do_txn(0, 32'h2C, 32'h0, 0, 0, 0, 0, 16, 2'b00, 2'b00, 0);
    do_txn(0, 32'h08, 32'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 10);

    // reset while AW/W are outstanding
    if (!abort_run) begin
      wait_idle();
      cfg_awd = 8; cfg_wd = 8;
      start_txn(1, 32'h30, 32'h77);
      @(negedge clk); #1;
      chk("aw_pending", {axi_awvalid, axi_wvalid}, 2'b11);
      #2;
      rst_n = 0;
      #1;
      chk("async_rst", {axi_awvalid, axi_wvalid, rsp_valid, cmd_ready},
          4'b0001);
      @(negedge clk); #1;
      rst_n = 1;
      @(negedge clk); #1;
      do_txn(0, 32'h30, 32'h0, 0, 0, 0, 1, 2, 2'b00, 2'b00, 0);
    end

    // randomized traffic
    for (int t = 0; t < 80 && !abort_run; t++) begin
      bit wr;
      logic [31:0] addr;
      int hold;
      wr = $urandom_range(0, 1);
      addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      hold = ($urandom_range(0, 9) == 9) ? 10 : $urandom_range(0, 2);
      do_txn(wr, addr, $urandom, pick_delay(), pick_delay(),
             pick_delay(), pick_delay(), pick_delay(),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
